// File: rtl/swervolf_btn_irq_if.sv
// Wishbone classic slave bundle shared by the button interrupt block and its bus master.
// Signal names keep the slave-side i_/o_ prefixes so they line up with the syscon fabric.
interface swervolf_btn_irq_if;
    logic [3:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/swervolf_btn_irq.sv
// Button/switch conditioner: synchronize, debounce, edge-detect into sticky pending bits,
// and raise a level interrupt for syscon gpio_irq. Software access over Wishbone.
module swervolf_btn_irq #(
    parameter int N_BTN     = 5,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_BTN-1:0]   i_btn,
    swervolf_btn_irq_if.slave  wb,
    output logic               o_irq
);

    typedef enum logic [1:0] {
        REG_STATE   = 2'd0,
        REG_RISE_EN = 2'd1,
        REG_FALL_EN = 2'd2,
        REG_PENDING = 2'd3
    } reg_sel_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] rise_en_q, rise_en_d;
    logic [N_BTN-1:0] fall_en_q, fall_en_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdt_q, rdt_d;

    reg_sel_e         reg_sel;
    logic             reg_we;
    logic [N_BTN-1:0] wdat;
    logic [N_BTN-1:0] rise, fall, set_mask, clr_mask;
    logic             unused_bits;

    // Address bits [1:0], upper byte selects and upper data bits are don't-cares.
    assign unused_bits = ^{wb.i_wb_adr[1:0], wb.i_wb_sel[3:1], wb.i_wb_dat[31:N_BTN]};

    always_comb begin
        reg_sel = reg_sel_e'(wb.i_wb_adr[3:2]);
        reg_we  = wb.i_wb_cyc & wb.i_wb_stb & wb.i_wb_we & ~ack_q & wb.i_wb_sel[0];
        wdat    = wb.i_wb_dat[N_BTN-1:0];
    end

    // Any sample matching the accepted level restarts the count, so only an
    // uninterrupted run of DB_CYCLES differing samples moves stable.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sync1_d      = i_btn;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        rise     = stable_q & ~stable_dly_q;
        fall     = ~stable_q & stable_dly_q;
        set_mask = (rise & rise_en_q) | (fall & fall_en_q);
        clr_mask = (reg_we && reg_sel == REG_PENDING) ? wdat : '0;

        rise_en_d = (reg_we && reg_sel == REG_RISE_EN) ? wdat : rise_en_q;
        fall_en_d = (reg_we && reg_sel == REG_FALL_EN) ? wdat : fall_en_q;
        // A new edge in the same cycle as its W1C clear must not be lost.
        pending_d = (pending_q & ~clr_mask) | set_mask;
        irq_d     = |pending_q;
        ack_d     = wb.i_wb_cyc & ~ack_q;

        rdt_d = '0;
        unique case (reg_sel)
            REG_STATE:   rdt_d = 32'(stable_q);
            REG_RISE_EN: rdt_d = 32'(rise_en_q);
            REG_FALL_EN: rdt_d = 32'(fall_en_q);
            REG_PENDING: rdt_d = 32'(pending_q);
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            pending_q    <= '0;
            irq_q        <= 1'b0;
            ack_q        <= 1'b0;
            rdt_q        <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            pending_q    <= pending_d;
            irq_q        <= irq_d;
            ack_q        <= ack_d;
            rdt_q        <= rdt_d;
        end
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_rdt = rdt_q;
    assign o_irq       = irq_q;

endmodule

// File: doc/swervolf_btn_irq.md
Name: swervolf_btn_irq

Overview:
- Pushbutton/switch input conditioner that feeds the gpio_irq input of swervolf_syscon.
- Per input: 2-flop synchronizer, counter-based debouncer, rise/fall edge detect, sticky pending bits.
- Raises a level interrupt whenever any pending bit is set.
- Wishbone slave on the same bus fabric as syscon; software reads debounced levels, programs edge enables and clears pending bits.

Parameters:
- N_BTN, 5, number of inputs (1..8).
- DB_CYCLES, 1000000, cycles a synchronized input must hold a new level before it is accepted (10 ms at 100 MHz); minimum 2.
- CNT_W, $clog2(DB_CYCLES), debounce counter width.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_btn  in  N_BTN  raw asynchronous button/switch levels.
- i_wb_adr  in  4  word address bits [3:2] used.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte selects; only [0] is used.
- i_wb_we  in  1  write strobe.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  acknowledge.
- o_irq  out  1  level interrupt to syscon gpio_irq.

Behaviour:
- Reset (async assert, sync release): sync flops, stable, counters, rise_en, fall_en and pending all 0; o_wb_ack=0; o_wb_rdt=0; o_irq=0.
- Reset mid-debounce discards the count. Stable returns to 0, so an input held high after reset produces one accepted rising edge after 2+DB_CYCLES cycles.
- Synchronizer: sync[i] = i_btn[i] delayed 2 edges.
- Debounce, per bit i:
  - sync==stable: cnt <= 0.
  - sync!=stable and cnt<DB_CYCLES-1: cnt <= cnt+1.
  - sync!=stable and cnt==DB_CYCLES-1: stable <= sync, cnt <= 0.
  - Any glitch back to the stable level restarts the count from 0.
  - Net latency from a clean i_btn change to stable: 2+DB_CYCLES edges.
- Edge detect (registered copy stable_d):
  - rise = stable & ~stable_d
  - fall = ~stable & stable_d
  - Each is one cycle wide.
- Pending set: pending[i] <= 1 on (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
- Pending clear: W1C write to PENDING clears the bits written as 1.
  - Set and clear of the same bit in the same cycle: set wins.
  - Disabling an enable does not clear an existing pending bit.
- o_irq <= |pending (registered): asserts 1 cycle after pending sets, deasserts 1 cycle after the last bit clears.
- Wishbone:
  - o_wb_ack <= i_wb_cyc & !o_wb_ack: single-cycle ack, 1-cycle latency, never back-to-back.
  - Write qualifier: reg_we = cyc & stb & we & !ack; writes take effect only when i_wb_sel[0]=1.
  - o_wb_rdt is registered every cycle from i_wb_adr; bits above N_BTN read 0.
- Register map (i_wb_adr[3:2]):
  - 0 STATE: RO debounced stable levels; writes ignored.
  - 1 RISE_EN: RW.
  - 2 FALL_EN: RW.
  - 3 PENDING: read = pending; write = W1C.
- Width rules:
  - Writes use i_wb_dat[N_BTN-1:0]; upper bits are ignored.
  - Counter never exceeds DB_CYCLES-1; no wrap.

Test Plan (DB_CYCLES=4, N_BTN=5):
- Reset, read addr 0..3 -> all read 0x00000000; o_irq=0; each ack one cycle after cyc.
- RISE_EN=0x01; raise i_btn[0] clean -> STATE bit0=1 exactly 6 edges after change; pending=0x01 next edge; o_irq=1 one edge later.
- i_btn[1] pulses high for 3 cycles then low, with RISE_EN=0x1F -> STATE unchanged 0x00, no pending, o_irq stays 0; a 4-cycle hold is accepted.
- FALL_EN=0x04; btn2 high then low (both held 6+ cycles) -> rising ignored; falling sets pending=0x04. Write PENDING=0x04 -> pending=0, o_irq drops 1 cycle later.
- Force a rise on bit3 (enabled) in the same cycle as a W1C write of 0x08 -> pending bit3 remains 1.
- Assert i_rst asynchronously with cnt=2 on bit4 and pending=0x10 -> everything 0 immediately. Hold btn4 high after release -> STATE=0x10 after 6 edges.
